sdfm_res_arb: RTL and testbench

Result arbiter and buffer for the sigma-delta filter channels. Collects the per-channel filter-data-update pulses and 32-bit filter outputs from NCH filter units. Serialises them through a round-robin arbiter into a small result FIFO, which the host register/DMA side drains with a valid/ready handshake. Also reports per-channel sample loss (overrun) and raises a FIFO-level interrupt.

---
 rtl/sdfm_pkg.sv | 22 ++
 rtl/sdfm_res_fifo.sv | 62 ++++++
 rtl/sdfm_res_arb.sv | 113 +++++++++++
 tb/tb_sdfm_res_arb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdfm_pkg.sv
// Shared constants, result-entry type and sizing helper for the
// sigma-delta filter result path.
package sdfm_pkg;

   localparam int SDFM_DATA_W     = 32;
   localparam int SDFM_NCH_DEF    = 4;
   localparam int SDFM_DEPTH_DEF  = 4;
   localparam int SDFM_CHAN_W_MAX = 3;

   typedef struct packed {
      logic [SDFM_CHAN_W_MAX-1:0] chan;
      logic [SDFM_DATA_W-1:0]     data;
   } sdfm_res_t;

   function automatic int sdfm_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/sdfm_res_fifo.sv
// Register-based synchronous FIFO with level/full/empty; head is read
// combinationally so a push is visible on the next cycle.
module sdfm_res_fifo
   import sdfm_pkg::*;
#(
   parameter  int DEPTH = SDFM_DEPTH_DEF,
   parameter  int W     = SDFM_DATA_W + 2,
   localparam int AW    = sdfm_clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_pop,
   output logic [W-1:0]  o_rdata,
   output logic [LW-1:0] o_level,
   output logic          o_full,
   output logic          o_empty
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == LW'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_rdata   = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   // NOTE: the storage is reset too, so the head reads zero straight out of reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/sdfm_res_arb.sv
// Per-channel capture, round-robin arbitration into the result FIFO,
// sticky overrun flags and a registered FIFO-level interrupt.
module sdfm_res_arb
   import sdfm_pkg::*;
#(
   parameter  int NCH   = SDFM_NCH_DEF,
   parameter  int DEPTH = SDFM_DEPTH_DEF,
   localparam int CW    = sdfm_clog2(NCH),
   localparam int LW    = sdfm_clog2(DEPTH) + 1
) (
   input  logic                       SYSCLK,
   input  logic                       SYSRSTn,
   input  logic [SDFM_DATA_W*NCH-1:0] ch_data_in,
   input  logic [NCH-1:0]             ch_update_in,
   input  logic [NCH-1:0]             ch_en_in,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [SDFM_DATA_W-1:0]     res_data,
   output logic [CW-1:0]              res_chan,
   output logic [LW-1:0]              fifo_level,
   input  logic [LW-1:0]              irq_thresh,
   output logic                       irq,
   output logic [NCH-1:0]             ovf_flags,
   input  logic [NCH-1:0]             ovf_clr
);

   localparam int EW = CW + SDFM_DATA_W;

   logic [NCH-1:0][SDFM_DATA_W-1:0] r_hold;
   logic [NCH-1:0]                  r_pend;
   logic [NCH-1:0]                  r_ovf;
   logic [CW-1:0]                   r_last_grant;
   logic                            r_irq;

   logic [NCH-1:0] w_capture;
   logic [NCH-1:0] w_gnt_oh;
   logic [NCH-1:0] w_ovf_set;
   logic [CW-1:0]  w_winner;
   logic [CW-1:0]  w_idx;
   logic           w_found;
   logic           w_grant;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic [EW-1:0]  w_push_ent;
   logic [EW-1:0]  w_head;
   logic [LW-1:0]  w_level;

   assign w_capture = ch_update_in & ch_en_in;
   assign w_pop     = res_valid && res_ready;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_last_grant;
      w_idx    = r_last_grant;
      for (int k = 1; k <= NCH; k++) begin
         w_idx = r_last_grant + CW'(k);
         if (!w_found && r_pend[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // A full FIFO still accepts a write when its head leaves in the same cycle.
   assign w_grant    = w_found && (!w_full || w_pop);
   assign w_gnt_oh   = w_grant ? (NCH'(1) << w_winner) : '0;
   assign w_ovf_set  = w_capture & r_pend & ~w_gnt_oh;
   assign w_push_ent = {w_winner, r_hold[w_winner]};

   always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
      if (!SYSRSTn) begin
         r_hold       <= '0;
         r_pend       <= '0;
         r_ovf        <= '0;
         r_last_grant <= CW'(NCH - 1);
         r_irq        <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_capture[i]) r_hold[i] <= ch_data_in[SDFM_DATA_W*i +: SDFM_DATA_W];
         end
         // Granting the old sample while capturing a new one leaves pend set.
         r_pend <= ch_en_in & (w_capture | (r_pend & ~w_gnt_oh));
         r_ovf  <= w_ovf_set | (r_ovf & ~ovf_clr);
         if (w_grant) r_last_grant <= w_winner;
         r_irq  <= (irq_thresh != '0) && (w_level >= irq_thresh);
      end
   end

   sdfm_res_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .i_clk   (SYSCLK),
      .i_rst_n (SYSRSTn),
      .i_push  (w_grant),
      .i_wdata (w_push_ent),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign res_valid  = !w_empty;
   assign res_data   = w_head[SDFM_DATA_W-1:0];
   assign res_chan   = w_head[EW-1 -: CW];
   assign fifo_level = w_level;
   assign irq        = r_irq;
   assign ovf_flags  = r_ovf;

endmodule

// File: tb/tb_sdfm_res_arb.sv
// Directed bench for sdfm_res_arb: a queue-based reference model is compared
// every cycle, and hand-computed literals pin the key scenarios.
module tb_sdfm_res_arb;
   import sdfm_pkg::*;

   localparam int NCH   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 2;
   localparam int LW    = 3;

   logic                       clk;
   logic                       rst_n;
   logic [SDFM_DATA_W*NCH-1:0] ch_data_in;
   logic [NCH-1:0]             ch_update_in;
   logic [NCH-1:0]             ch_en_in;
   logic                       res_valid;
   logic                       res_ready;
   logic [SDFM_DATA_W-1:0]     res_data;
   logic [CW-1:0]              res_chan;
   logic [LW-1:0]              fifo_level;
   logic [LW-1:0]              irq_thresh;
   logic                       irq;
   logic [NCH-1:0]             ovf_flags;
   logic [NCH-1:0]             ovf_clr;

   int n_checks = 0;
   int n_errors = 0;

   sdfm_res_arb #(.NCH(NCH), .DEPTH(DEPTH)) dut (
      .SYSCLK       (clk),
      .SYSRSTn      (rst_n),
      .ch_data_in   (ch_data_in),
      .ch_update_in (ch_update_in),
      .ch_en_in     (ch_en_in),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_chan     (res_chan),
      .fifo_level   (fifo_level),
      .irq_thresh   (irq_thresh),
      .irq          (irq),
      .ovf_flags    (ovf_flags),
      .ovf_clr      (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   sdfm_res_t        m_q[$];
   logic [31:0]      m_hold [NCH];
   bit               m_pend [NCH];
   bit               m_old_pend [NCH];
   logic [NCH-1:0]   m_ovf = '0;
   bit               m_irq = 1'b0;
   int               m_lg  = NCH - 1;
   int               m_lvl;
   int               m_win;
   bit               m_pop;
   bit               m_grant;
   sdfm_res_t        m_ent;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         for (int i = 0; i < NCH; i++) begin
            m_hold[i] = '0;
            m_pend[i] = 1'b0;
         end
         m_ovf = '0;
         m_irq = 1'b0;
         m_lg  = NCH - 1;
      end else begin
         m_lvl = m_q.size();
         m_pop = (m_lvl > 0) && res_ready;
         m_win = -1;
         for (int k = 1; k <= NCH; k++)
            if (m_win < 0 && m_pend[(m_lg + k) % NCH]) m_win = (m_lg + k) % NCH;
         m_grant = (m_win >= 0) && ((m_lvl < DEPTH) || m_pop);
         m_irq   = (irq_thresh != 0) && (m_lvl >= int'(irq_thresh));
         for (int i = 0; i < NCH; i++) m_old_pend[i] = m_pend[i];
         if (m_pop) void'(m_q.pop_front());
         if (m_grant) begin
            m_ent.chan = 3'(m_win);
            m_ent.data = m_hold[m_win];
            m_q.push_back(m_ent);
            m_pend[m_win] = 1'b0;
            m_lg = m_win;
         end
         for (int i = 0; i < NCH; i++) begin
            if (!ch_en_in[i]) begin
               m_pend[i] = 1'b0;
               if (ovf_clr[i]) m_ovf[i] = 1'b0;
            end else if (ch_update_in[i]) begin
               if (m_old_pend[i] && !(m_grant && m_win == i)) m_ovf[i] = 1'b1;
               else if (ovf_clr[i]) m_ovf[i] = 1'b0;
               m_hold[i] = ch_data_in[32*i +: 32];
               m_pend[i] = 1'b1;
            end else if (ovf_clr[i]) begin
               m_ovf[i] = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_valid", res_valid, m_q.size() > 0);
      check("cyc_level", fifo_level, m_q.size());
      check("cyc_irq", irq, m_irq);
      check("cyc_ovf", ovf_flags, m_ovf);
      if (m_q.size() > 0) begin
         check("cyc_data", res_data, m_q[0].data);
         check("cyc_chan", res_chan, m_q[0].chan);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [31:0] v);
      ch_data_in[32*ch +: 32] = v;
   endtask

   task automatic drain(input string name);
      res_ready = 1'b1;
      for (int k = 0; k < 20 && res_valid; k++) tick();
      check(name, res_valid, 1'b0);
      res_ready = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      ch_data_in   = '0;
      ch_update_in = '0;
      ch_en_in     = '1;
      res_ready    = 1'b0;
      irq_thresh   = '0;
      ovf_clr      = '0;
      repeat (3) tick();
      check("rst_valid", res_valid, 0);
      check("rst_data", res_data, 0);
      check("rst_chan", res_chan, 0);
      check("rst_level", fifo_level, 0);
      check("rst_irq", irq, 0);
      check("rst_ovf", ovf_flags, 0);
      rst_n = 1'b1;
      tick();

      // Contention: all four channels at once, drained in order 0..3.
      for (int i = 0; i < NCH; i++) set_data(i, 32'hA0 + i);
      ch_update_in = 4'b1111;
      res_ready = 1'b1;
      tick();
      ch_update_in = '0;
      for (int i = 0; i < NCH; i++) begin
         tick();
         check("cont_chan", res_chan, i);
         check("cont_data", res_data, 32'hA0 + i);
      end
      tick();
      check("cont_empty", res_valid, 0);
      check("cont_ovf", ovf_flags, 0);
      res_ready = 1'b0;

      // Single channel latency: update in N, valid in N+2.
      set_data(2, 32'h0000_1234);
      ch_update_in = 4'b0100;
      tick();
      ch_update_in = '0;
      check("single_n1_valid", res_valid, 0);
      tick();
      check("single_valid", res_valid, 1);
      check("single_data", res_data, 32'h1234);
      check("single_chan", res_chan, 2);
      check("single_level1", fifo_level, 1);
      tick();
      check("single_hold_data", res_data, 32'h1234);
      res_ready = 1'b1;
      tick();
      check("single_level0", fifo_level, 0);
      res_ready = 1'b0;

      // Disabled channel ignores updates.
      ch_en_in = 4'b1011;
      set_data(2, 32'h999);
      ch_update_in = 4'b0100;
      tick();
      ch_update_in = '0;
      tick();
      tick();
      check("dis_valid", res_valid, 0);
      ch_en_in = '1;

      // Back-pressure: saturate the FIFO, then overrun ch1.
      for (int k = 0; k < 6; k++) begin
         int ch;
         ch = (k % 2 == 1) ? 3 : 1;
         set_data(ch, 32'((ch << 8) | (1 + k / 2)));
         ch_update_in = NCH'(1 << ch);
         tick();
      end
      ch_update_in = '0;
      check("bp_level_sat", fifo_level, 4);
      check("bp_no_ovf", ovf_flags, 0);
      set_data(1, 32'h104);
      ch_update_in = 4'b0010;
      tick();
      check("bp_ovf_set", ovf_flags, 4'b0010);
      set_data(1, 32'h105);
      ovf_clr = 4'b0010;
      tick();
      check("bp_set_beats_clr", ovf_flags, 4'b0010);
      ch_update_in = '0;
      tick();
      check("bp_clr", ovf_flags, 4'b0000);
      ovf_clr = '0;
      res_ready = 1'b1;
      tick();
      check("bp_full_pop_push_chan", res_chan, 3);
      check("bp_full_pop_push_data", res_data, 32'h301);
      check("bp_full_pop_push_level", fifo_level, 4);
      drain("bp_drain");

      // Same-cycle capture and grant on ch0.
      set_data(0, 32'h11);
      ch_update_in = 4'b0001;
      tick();
      set_data(0, 32'h22);
      tick();
      ch_update_in = '0;
      check("scg_first", res_data, 32'h11);
      tick();
      check("scg_level", fifo_level, 2);
      check("scg_ovf", ovf_flags, 0);
      res_ready = 1'b1;
      tick();
      check("scg_second", res_data, 32'h22);
      check("scg_second_chan", res_chan, 0);
      tick();
      res_ready = 1'b0;

      // Interrupt threshold.
      irq_thresh = 3'd2;
      set_data(1, 32'h501);
      ch_update_in = 4'b0010;
      tick();
      set_data(2, 32'h502);
      ch_update_in = 4'b0100;
      tick();
      ch_update_in = '0;
      tick();
      check("irq_level2", fifo_level, 2);
      check("irq_lag", irq, 0);
      tick();
      check("irq_set", irq, 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("irq_pop_level", fifo_level, 1);
      check("irq_still", irq, 1);
      tick();
      check("irq_clear", irq, 0);
      irq_thresh = '0;
      set_data(3, 32'h503);
      ch_update_in = 4'b1000;
      tick();
      ch_update_in = '0;
      repeat (3) tick();
      check("irq_dis_level", fifo_level, 2);
      check("irq_disabled", irq, 0);

      // Reset mid-operation with three entries and pending channels.
      for (int i = 0; i < 3; i++) set_data(i, 32'h600 + i);
      ch_update_in = 4'b0111;
      tick();
      set_data(1, 32'h611);
      ch_update_in = 4'b0010;
      tick();
      ch_update_in = '0;
      check("prerst_level", fifo_level, 3);
      check("prerst_ovf", ovf_flags, 4'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", res_valid, 0);
      check("mrst_level", fifo_level, 0);
      check("mrst_data", res_data, 0);
      check("mrst_chan", res_chan, 0);
      check("mrst_irq", irq, 0);
      check("mrst_ovf", ovf_flags, 0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("postrst_no_pend", fifo_level, 0);
      set_data(0, 32'h700);
      set_data(1, 32'h701);
      set_data(3, 32'h703);
      ch_update_in = 4'b1011;
      tick();
      ch_update_in = '0;
      tick();
      check("postrst_first_chan", res_chan, 0);
      check("postrst_first_data", res_data, 32'h700);
      drain("postrst_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
